mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit that owns the HI/LO register pair. It sits beside the pipeline ALU in the execute stage and replaces the single-cycle HI/LO multiply path. Supports signed/unsigned multiply, signed/unsigned divide, MTHI/MTLO and flush. A start/busy handshake lets the hazard unit stall MFHI/MFLO and back-to-back HI/LO ops.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when busy=0.
op  input  3  operation code (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
a  input  WIDTH  rs operand (multiplicand/dividend/MTHI/MTLO data).
b  input  WIDTH  rt operand (multiplier/divisor).
flush  input  1  abort any in-flight op; HI/LO keep pre-op values.
busy  output  1  registered; high while state != IDLE.
done  output  1  one-cycle pulse when an arithmetic result is committed to HI/LO.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset_n=0, any time, including mid-op): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0; takes effect immediately, without waiting for a clock edge.
- States: IDLE, CALC, FIX.
- IDLE + start + MD_MTHI/MD_MTLO: hi (or lo) <= a at that edge; remain IDLE; done stays 0.
- IDLE + start + arithmetic op: latch operands as magnitudes (signed ops take two's-complement absolute value), latch result sign(s); counter <= 0; go to CALC.
- CALC: one radix-2 step per cycle. Multiply is shift-add over a 2*WIDTH accumulator. Divide is restoring shift-subtract giving quotient and remainder magnitudes. After WIDTH steps, go to FIX.
- FIX: apply sign correction.
  - Product is negated if sign(a)^sign(b).
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of the dividend.
  - Commit: multiply -> {hi,lo} <= product; divide -> lo <= quotient, hi <= remainder.
  - Then done=1 for exactly one cycle and return to IDLE.
- Latency: start edge T0; busy=1 for cycles T0+1 .. T0+WIDTH+1; hi/lo/done update at edge T0+WIDTH+1; busy=0 after that edge. Total is WIDTH+1 busy cycles.
- start while busy=1: ignored, no queueing. The pipeline must stall on busy.
- flush: highest priority after reset. Any state goes to IDLE at the next edge; no commit, no done. A flush coinciding with the FIX edge also suppresses the commit. flush with start in IDLE drops the start.
- Divide by zero (b=0):
  - Completes with normal latency.
  - lo <= all ones; hi <= a (raw input, no sign correction).
  - done pulses.
- Signed overflow (DIV of INT_MIN by -1): lo <= INT_MIN, hi <= 0. This is the natural result of the magnitude algorithm and needs no special case.
- hi/lo are stable at all times except on commit or MTHI/MTLO edges. Reads are combinational from the registers.

Decomposition:
- Shared package/header (alongside the ISA definitions):
  - op codes: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5.
  - state encodings: IDLE/CALC/FIX.
- One natural sub-module: md_step, the combinational single-iteration datapath. Inputs are mode and accumulator/remainder/quotient; outputs are the next values. This keeps the FSM/counter in mul_div_unit and lets md_step be unit-tested exhaustively at WIDTH=4.

Test Plan:
- MULTU a=111111, b=222222 -> after 33 busy cycles done=1; hi=32'h00000005, lo=32'hBFB77862.
- MULT a=-111111, b=222222 -> hi=32'hFFFFFFFA, lo=32'h4048879E; same latency; busy drops the cycle done pulses.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- Corner cases:
  - DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5.
  - DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
- MTHI a=32'h1234 then MULTU with flush pulsed at busy cycle 10 -> done never asserts, hi=32'h1234, lo unchanged. A start during busy is ignored (hi/lo match the single-op result).
- Reset asserted mid-CALC without a clock edge -> busy=0, hi=lo=0 immediately. After release, a fresh MULTU 3*4 gives lo=12, hi=0. Repeat at WIDTH=8: latency is 9 cycles and results match.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// operation codes and controller state encodings.
package mul_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply on {partial, multiplier},
// or restoring shift-subtract divide on {remainder, quotient}.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  // Compute both candidate updates and select by mode
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    partial  = acc[2*WIDTH-1:WIDTH-1];
    trial    = partial - {1'b0, operand};
    acc_next = acc;
    if (is_div) begin
      // trial MSB set means the divisor did not fit: restore
      if (!trial[WIDTH]) begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. Operands are processed as
// magnitudes for WIDTH cycles, then sign-corrected and committed in FIX.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  md_state_e          state, state_next;
  logic [CNT_W-1:0]   counter, counter_next;
  logic [2*WIDTH-1:0] acc, acc_next, step_acc;
  logic [WIDTH-1:0]   operand, operand_next;
  logic               is_div, is_div_next;
  logic               neg_res, neg_res_next;
  logic               neg_rem, neg_rem_next;
  logic               div_zero, div_zero_next;
  logic               busy_next, done_next;
  logic [WIDTH-1:0]   hi_next, lo_next;
  logic               is_arith, is_signed, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0] product;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (step_acc)
  );

  // Operand decode and sign-corrected views of the accumulator
  always_comb begin
    is_arith  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    sign_a    = is_signed & a[WIDTH-1];
    sign_b    = is_signed & b[WIDTH-1];
    mag_a     = sign_a ? -a : a;
    mag_b     = sign_b ? -b : b;
    product   = neg_res ? -acc : acc;
    quo       = acc[WIDTH-1:0];
    rem       = acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything but reset
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && is_arith) begin
            state_next = CALC;
          end else begin
            state_next = IDLE;
          end
        end
        CALC: begin
          if (counter == LAST_STEP) begin
            state_next = FIX;
          end else begin
            state_next = CALC;
          end
        end
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    counter_next  = counter;
    acc_next      = acc;
    operand_next  = operand;
    is_div_next   = is_div;
    neg_res_next  = neg_res;
    neg_rem_next  = neg_rem;
    div_zero_next = div_zero;
    hi_next       = hi;
    lo_next       = lo;
    done_next     = 1'b0;
    busy_next     = (state_next != IDLE);
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (op == MD_MTHI) begin
            hi_next = a;
          end else if (op == MD_MTLO) begin
            lo_next = a;
          end else if (is_arith) begin
            is_div_next   = (op == MD_DIV) || (op == MD_DIVU);
            neg_res_next  = sign_a ^ sign_b;
            neg_rem_next  = sign_a;
            div_zero_next = (b == {WIDTH{1'b0}});
            counter_next  = {CNT_W{1'b0}};
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend
            if ((op == MD_DIV) || (op == MD_DIVU)) begin
              acc_next     = {{WIDTH{1'b0}}, mag_a};
              operand_next = mag_b;
            end else begin
              acc_next     = {{WIDTH{1'b0}}, mag_b};
              operand_next = mag_a;
            end
          end else begin
            counter_next = counter;
          end
        end else begin
          counter_next = counter;
        end
      end
      CALC: begin
        acc_next     = step_acc;
        counter_next = counter + CNT_ONE;
      end
      FIX: begin
        if (!flush) begin
          done_next = 1'b1;
          if (is_div) begin
            lo_next = div_zero ? {WIDTH{1'b1}} : (neg_res ? -quo : quo);
            hi_next = neg_rem ? -rem : rem;
          end else begin
            {hi_next, lo_next} = product;
          end
        end else begin
          done_next = 1'b0;
        end
      end
      default: begin
        done_next = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter  <= {CNT_W{1'b0}};
      acc      <= {(2*WIDTH){1'b0}};
      operand  <= {WIDTH{1'b0}};
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      counter  <= counter_next;
      acc      <= acc_next;
      operand  <= operand_next;
      is_div   <= is_div_next;
      neg_res  <= neg_res_next;
      neg_rem  <= neg_rem_next;
      div_zero <= div_zero_next;
      busy     <= busy_next;
      done     <= done_next;
      hi       <= hi_next;
      lo       <= lo_next;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit at WIDTH=32 and WIDTH=8: spec vectors, random ops
// against an arithmetic reference model, and flush/reset/busy corner sequences.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .flush(flush), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ob_busy(input int w);
    return (w == 8) ? busy8 : busy32;
  endfunction
  function automatic logic ob_done(input int w);
    return (w == 8) ? done8 : done32;
  endfunction
  function automatic logic [31:0] ob_hi(input int w);
    return (w == 8) ? {24'd0, hi8} : hi32;
  endfunction
  function automatic logic [31:0] ob_lo(input int w);
    return (w == 8) ? {24'd0, lo8} : lo32;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v;
    else start32 = v;
  endtask

  // Arithmetic reference: plain integer multiply/divide on w-bit values
  function automatic void ref_md(input int w, input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y, inout logic [31:0] h, inout logic [31:0] l);
    logic [63:0] ux, uy, mask, p;
    longint sx, sy, q, r;
    mask = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & mask;
    uy = {32'd0, y} & mask;
    sx = ux[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
    sy = uy[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
    case (o)
      MD_MULT, MD_MULTU: begin
        p = (o == MD_MULT) ? 64'(sx * sy) : ux * uy;
        l = 32'(p & mask);
        h = 32'((p >> w) & mask);
      end
      MD_DIV, MD_DIVU: begin
        if (uy == 64'd0) begin
          l = 32'(mask);
          h = 32'(ux);
        end else if (o == MD_DIVU) begin
          l = 32'(ux / uy);
          h = 32'(ux % uy);
        end else begin
          q = sx / sy;
          r = sx % sy;
          l = 32'(64'(q) & mask);
          h = 32'(64'(r) & mask);
        end
      end
      MD_MTHI: h = 32'(ux);
      MD_MTLO: l = 32'(ux);
      default: begin end
    endcase
  endfunction

  task automatic run_op(input int w, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input string tag);
    int k;
    int bcnt;
    int idx;
    idx = (w == 8) ? 1 : 0;
    @(negedge clk);
    op = o; a = x; b = y;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    ref_md(w, o, x, y, m_hi[idx], m_lo[idx]);
    if (o == MD_MTHI || o == MD_MTLO) begin
      check({tag, " mt done"}, 64'(ob_done(w)), 64'd0);
      check({tag, " mt busy"}, 64'(ob_busy(w)), 64'd0);
    end else begin
      k = 0;
      bcnt = 0;
      while (!ob_done(w) && k < 200) begin
        if (ob_busy(w)) bcnt++;
        @(negedge clk);
        k++;
      end
      check({tag, " latency"}, 64'(k), 64'(w + 1));
      check({tag, " busy cycles"}, 64'(bcnt), 64'(w + 1));
      check({tag, " busy at done"}, 64'(ob_busy(w)), 64'd0);
      check({tag, " hi"}, 64'(ob_hi(w)), 64'(m_hi[idx]));
      check({tag, " lo"}, 64'(ob_lo(w)), 64'(m_lo[idx]));
      @(negedge clk);
      check({tag, " done pulse"}, 64'(ob_done(w)), 64'd0);
    end
    check({tag, " hi final"}, 64'(ob_hi(w)), 64'(m_hi[idx]));
    check({tag, " lo final"}, 64'(ob_lo(w)), 64'(m_lo[idx]));
  endtask

  task automatic watch_no_done(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (done32) seen = 1'b1;
      @(negedge clk);
    end
    check({tag, " no done"}, 64'(seen), 64'd0);
    check({tag, " busy"}, 64'(busy32), 64'd0);
    check({tag, " hi"}, 64'(hi32), 64'(m_hi[0]));
    check({tag, " lo"}, 64'(lo32), 64'(m_lo[0]));
  endtask

  initial begin
    vec_t vecs [10];
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int k;

    vecs[0] = '{MD_MULTU, 32'd111111, 32'd222222, 32'h00000005, 32'hBFB77862};
    vecs[1] = '{MD_MULT, -32'sd111111, 32'd222222, 32'hFFFFFFFA, 32'h4048879E};
    vecs[2] = '{MD_DIV, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[4] = '{MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
    vecs[5] = '{MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    vecs[6] = '{MD_DIV, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD};
    vecs[7] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[8] = '{MD_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9] = '{MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    for (int i = 0; i < 2; i++) begin
      m_hi[i] = 32'd0;
      m_lo[i] = 32'd0;
    end

    #12;
    check("reset busy", 64'(busy32), 64'd0);
    check("reset done", 64'(done32), 64'd0);
    check("reset hi", 64'(hi32), 64'd0);
    check("reset lo", 64'(lo32), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(32, vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table hi", i), 64'(hi32), 64'(vecs[i].hi));
      check($sformatf("vec%0d table lo", i), 64'(lo32), 64'(vecs[i].lo));
    end

    // MTHI then a MULTU flushed at busy cycle 10
    run_op(32, MD_MTHI, 32'h1234, 32'd0, "mthi");
    @(negedge clk);
    op = MD_MULTU; a = 32'd3; b = 32'd4; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    watch_no_done(40, "flush mid");
    check("flush keeps mthi", 64'(hi32), 64'h1234);

    // Flush landing on the commit edge
    @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (32) @(negedge clk);
    check("fix state busy", 64'(busy32), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    watch_no_done(5, "flush fix");

    // Flush together with start in IDLE drops the start
    @(negedge clk);
    op = MD_MTHI; a = 32'h55; start32 = 1'b1; flush = 1'b1;
    @(negedge clk);
    op = MD_MULTU;
    @(negedge clk);
    start32 = 1'b0; flush = 1'b0;
    watch_no_done(3, "flush idle");

    // Starts while busy are ignored
    @(negedge clk);
    op = MD_MULTU; a = 32'd1000; b = 32'd3000; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    ref_md(32, MD_MULTU, 32'd1000, 32'd3000, m_hi[0], m_lo[0]);
    repeat (5) @(negedge clk);
    op = MD_MTHI; a = 32'hDEAD; start32 = 1'b1;
    @(negedge clk);
    op = MD_DIVU; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    k = 7;
    while (!done32 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ignored start latency", 64'(k), 64'd33);
    check("ignored start hi", 64'(hi32), 64'(m_hi[0]));
    check("ignored start lo", 64'(lo32), 64'd3000000);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    op = MD_MULTU; a = 32'd111111; b = 32'd222222; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy32), 64'd0);
    check("async rst hi", 64'(hi32), 64'd0);
    check("async rst lo", 64'(lo32), 64'd0);
    for (int i = 0; i < 2; i++) begin
      m_hi[i] = 32'd0;
      m_lo[i] = 32'd0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(32, MD_MULTU, 32'd3, 32'd4, "post rst");
    check("post rst lo12", 64'(lo32), 64'd12);
    check("post rst hi0", 64'(hi32), 64'd0);

    // WIDTH=8 instance
    run_op(8, MD_MULTU, 32'd3, 32'd4, "w8 multu");
    check("w8 lo12", 64'(lo8), 64'd12);
    run_op(8, MD_DIV, 32'hF9, 32'd2, "w8 div");
    run_op(8, MD_DIV, 32'h80, 32'hFF, "w8 ovf");
    run_op(8, MD_DIVU, 32'h5, 32'd0, "w8 dz");

    // Randomised ops on both widths
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      rx = $urandom;
      case ($urandom_range(0, 9))
        0:       ry = 32'd0;
        1:       ry = 32'($urandom_range(1, 9));
        2:       ry = 32'hFFFFFFFF;
        default: ry = $urandom;
      endcase
      run_op((i % 2 == 0) ? 32 : 8, ro, rx, ry, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
